// File: rtl/ibex_fp_rf_pkg.sv
// Shared types and default widths for the multi-port FP register file.
package ibex_fp_rf_pkg;

  localparam int unsigned FpDataWidth = 32;
  localparam int unsigned FpNumRegs   = 32;
  localparam int unsigned FpAddrWidth = $clog2(FpNumRegs);

  typedef struct packed {
    logic [FpAddrWidth-1:0] addr;
    logic [FpDataWidth-1:0] data;
  } fp_wb_entry_t;

endpackage

// File: rtl/ibex_fp_rf_wb_fifo.sv
// Circular load-writeback buffer with head/tail pointers and occupancy count.
// Pointers wrap explicitly at Depth, so non-power-of-two depths are supported.
module ibex_fp_rf_wb_fifo import ibex_fp_rf_pkg::*; #(
  parameter int unsigned Depth   = 2,
  parameter type         entry_t = fp_wb_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  entry_t          buf_q [Depth];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] cnt_q;
  logic            push, pop;

  function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == DepthCnt);
  assign empty_o = (cnt_q == '0);
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;
  assign head_o  = buf_q[head_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) tail_q <= wrap_inc(tail_q);
      if (pop)  head_q <= wrap_inc(head_q);
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Payload storage carries no reset; validity is tracked by the count.
  always_ff @(posedge clk_i) begin
    if (push) buf_q[tail_q] <= push_data_i;
  end

endmodule

// File: rtl/ibex_fp_regfile_mp.sv
// Multi-port FP register file: LUTRAM storage, pending scoreboard and load-writeback buffer.
// Optional write/issue checking is enabled with IBEX_FP_RF_WB_CHECK_EN.
module ibex_fp_regfile_mp import ibex_fp_rf_pkg::*; #(
  parameter int unsigned          DataWidth   = FpDataWidth,
  parameter int unsigned          NumRegs     = FpNumRegs,
  parameter int unsigned          NumRead     = 3,
  parameter int unsigned          WbDepth     = 2,
  parameter bit                   ZeroReg     = 1'b0,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  localparam int unsigned         AW          = $clog2(NumRegs)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumRead-1:0][AW-1:0]        raddr_i,
  output logic [NumRead-1:0][DataWidth-1:0] rdata_o,
  output logic [NumRead-1:0]                rbusy_o,
  input  logic                              issue_valid_i,
  input  logic [AW-1:0]                     issue_addr_i,
  output logic                              issue_ready_o,
  input  logic                              fpu_we_i,
  input  logic [AW-1:0]                     fpu_waddr_i,
  input  logic [DataWidth-1:0]              fpu_wdata_i,
  input  logic                              ld_valid_i,
  output logic                              ld_ready_o,
  input  logic [AW-1:0]                     ld_waddr_i,
  input  logic [DataWidth-1:0]              ld_wdata_i,
  output logic                              err_o
);

  typedef struct packed {
    logic [AW-1:0]        addr;
    logic [DataWidth-1:0] data;
  } wb_entry_t;

  logic [DataWidth-1:0] mem [NumRegs] = '{default: WordZeroVal};
  logic [NumRegs-1:0]   pending_q, pending_d;

  wb_entry_t            wb_head, ld_entry;
  logic                 wb_full, wb_empty, wb_push, wb_pop, ld_hs;
  logic                 commit_valid, mem_we;
  logic [AW-1:0]        commit_addr;
  logic [DataWidth-1:0] commit_data;

  assign ld_entry   = '{addr: ld_waddr_i, data: ld_wdata_i};
  assign ld_ready_o = !wb_full;
  assign ld_hs      = ld_valid_i && ld_ready_o;

  ibex_fp_rf_wb_fifo #(
    .Depth   (WbDepth),
    .entry_t (wb_entry_t)
  ) u_wb_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (wb_push),
    .push_data_i (ld_entry),
    .pop_i       (wb_pop),
    .head_o      (wb_head),
    .full_o      (wb_full),
    .empty_o     (wb_empty)
  );

  // FPU first, then buffered loads, then a direct load when nothing is queued.
  always_comb begin
    commit_valid = 1'b1;
    commit_addr  = fpu_waddr_i;
    commit_data  = fpu_wdata_i;
    wb_pop       = 1'b0;
    wb_push      = ld_hs;
    if (fpu_we_i) begin
      commit_valid = 1'b1;
    end else if (!wb_empty) begin
      wb_pop      = 1'b1;
      commit_addr = wb_head.addr;
      commit_data = wb_head.data;
    end else if (ld_hs) begin
      wb_push     = 1'b0;
      commit_addr = ld_waddr_i;
      commit_data = ld_wdata_i;
    end else begin
      commit_valid = 1'b0;
    end
  end

  assign mem_we = commit_valid && !(ZeroReg && (commit_addr == '0));

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[commit_addr] <= commit_data;
  end

  // A same-cycle issue overrides the commit clear on the same register.
  always_comb begin
    pending_d = pending_q;
    if (commit_valid)  pending_d[commit_addr]  = 1'b0;
    if (issue_valid_i) pending_d[issue_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign issue_ready_o = !pending_q[issue_addr_i];

  for (genvar i = 0; i < NumRead; i++) begin : g_read
    assign rdata_o[i] = (ZeroReg && (raddr_i[i] == '0)) ? WordZeroVal : mem[raddr_i[i]];
    assign rbusy_o[i] = pending_q[raddr_i[i]];
  end

`ifdef IBEX_FP_RF_WB_CHECK_EN
  logic err_q, err_d;

  assign err_d = (commit_valid && !pending_q[commit_addr]) ||
                 (issue_valid_i && !issue_ready_o) ||
                 (ld_valid_i && wb_full);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_fp_regfile_mp.sv
// Directed testbench for ibex_fp_regfile_mp with hand-computed expectations.
module tb_ibex_fp_regfile_mp;

  localparam int unsigned DW  = 32;
  localparam int unsigned NR  = 32;
  localparam int unsigned NRD = 3;
  localparam int unsigned AW  = 5;

`ifdef IBEX_FP_RF_WB_CHECK_EN
  localparam logic ErrExp = 1'b1;
`else
  localparam logic ErrExp = 1'b0;
`endif

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic [NRD-1:0][AW-1:0]  raddr;
  logic [NRD-1:0][DW-1:0]  rdata;
  logic [NRD-1:0]          rbusy;
  logic                    issue_valid;
  logic [AW-1:0]           issue_addr;
  logic                    issue_ready;
  logic                    fpu_we;
  logic [AW-1:0]           fpu_waddr;
  logic [DW-1:0]           fpu_wdata;
  logic                    ld_valid;
  logic                    ld_ready;
  logic [AW-1:0]           ld_waddr;
  logic [DW-1:0]           ld_wdata;
  logic                    err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  ibex_fp_regfile_mp #(
    .DataWidth   (DW),
    .NumRegs     (NR),
    .NumRead     (NRD),
    .WbDepth     (2),
    .ZeroReg     (1'b0),
    .WordZeroVal ('0)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .raddr_i       (raddr),
    .rdata_o       (rdata),
    .rbusy_o       (rbusy),
    .issue_valid_i (issue_valid),
    .issue_addr_i  (issue_addr),
    .issue_ready_o (issue_ready),
    .fpu_we_i      (fpu_we),
    .fpu_waddr_i   (fpu_waddr),
    .fpu_wdata_i   (fpu_wdata),
    .ld_valid_i    (ld_valid),
    .ld_ready_o    (ld_ready),
    .ld_waddr_i    (ld_waddr),
    .ld_wdata_i    (ld_wdata),
    .err_o         (err)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    issue_addr  = '0;
    fpu_we      = 1'b0;
    fpu_waddr   = '0;
    fpu_wdata   = '0;
    ld_valid    = 1'b0;
    ld_waddr    = '0;
    ld_wdata    = '0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle();
    raddr = '0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i    = 1'b0;
    raddr[0] = 5'd0;
    raddr[1] = 5'd5;
    raddr[2] = 5'd31;
    #2;
    for (int i = 0; i < NRD; i++) begin
      n_checks++;
      if (rdata[i] !== 32'h0) begin
        n_errors++;
        $display("FAIL reset_rdata[%0d]: got %h expected %h", i, rdata[i], 32'h0);
      end
      n_checks++;
      if (rbusy[i] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_rbusy[%0d]: got %b expected 0", i, rbusy[i]);
      end
    end
    n_checks++;
    if (ld_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_ld_ready: got %b expected 1", ld_ready);
    end
    n_checks++;
    if (issue_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_issue_ready: got %b expected 1", issue_ready);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_err: got %b expected 0", err);
    end
  endtask

  task automatic test_issue_fpu();
    step();
    issue_valid = 1'b1;
    issue_addr  = 5'd3;
    raddr[0]    = 5'd3;
    step();
    issue_valid = 1'b0;
    #2;
    n_checks++;
    if (rbusy[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL issue_rbusy_c1: got %b expected 1", rbusy[0]);
    end
    step();
    fpu_we    = 1'b1;
    fpu_waddr = 5'd3;
    fpu_wdata = 32'h3F80_0000;
    #2;
    n_checks++;
    if (rbusy[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL issue_rbusy_c2: got %b expected 1", rbusy[0]);
    end
    step();
    fpu_we = 1'b0;
    #2;
    n_checks++;
    if (rdata[0] !== 32'h3F80_0000) begin
      n_errors++;
      $display("FAIL fpu_write_rdata: got %h expected %h", rdata[0], 32'h3F80_0000);
    end
    n_checks++;
    if (rbusy[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL fpu_write_rbusy: got %b expected 0", rbusy[0]);
    end
  endtask

  task automatic test_fpu_and_load();
    step();
    issue_valid = 1'b1;
    issue_addr  = 5'd1;
    step();
    issue_addr  = 5'd2;
    step();
    issue_valid = 1'b0;
    fpu_we      = 1'b1;
    fpu_waddr   = 5'd1;
    fpu_wdata   = 32'h1111_1111;
    ld_valid    = 1'b1;
    ld_waddr    = 5'd2;
    ld_wdata    = 32'hDEAD_BEEF;
    raddr[0]    = 5'd1;
    raddr[1]    = 5'd2;
    #2;
    n_checks++;
    if (ld_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL dual_ld_ready: got %b expected 1", ld_ready);
    end
    n_checks++;
    if (rbusy[1:0] !== 2'b11) begin
      n_errors++;
      $display("FAIL dual_pending_before: got %b expected 11", rbusy[1:0]);
    end
    step();
    fpu_we   = 1'b0;
    ld_valid = 1'b0;
    #2;
    n_checks++;
    if (rdata[0] !== 32'h1111_1111) begin
      n_errors++;
      $display("FAIL dual_f1_rdata: got %h expected %h", rdata[0], 32'h1111_1111);
    end
    n_checks++;
    if (rbusy[1:0] !== 2'b10) begin
      n_errors++;
      $display("FAIL dual_pending_mid: got %b expected 10", rbusy[1:0]);
    end
    n_checks++;
    if (rdata[1] !== 32'h0) begin
      n_errors++;
      $display("FAIL dual_f2_not_yet: got %h expected %h", rdata[1], 32'h0);
    end
    step();
    #2;
    n_checks++;
    if (rdata[1] !== 32'hDEAD_BEEF) begin
      n_errors++;
      $display("FAIL dual_f2_rdata: got %h expected %h", rdata[1], 32'hDEAD_BEEF);
    end
    n_checks++;
    if (rbusy[1] !== 1'b0) begin
      n_errors++;
      $display("FAIL dual_f2_rbusy: got %b expected 0", rbusy[1]);
    end
  endtask

  task automatic test_buffer_full();
    raddr[0] = 5'd10;
    raddr[1] = 5'd11;
    raddr[2] = 5'd12;
    step();
    fpu_we    = 1'b1;
    fpu_waddr = 5'd20;
    fpu_wdata = 32'h1;
    ld_valid  = 1'b1;
    ld_waddr  = 5'd10;
    ld_wdata  = 32'hA000_0010;
    #2;
    n_checks++;
    if (ld_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL full_ready_ld0: got %b expected 1", ld_ready);
    end
    step();
    fpu_wdata = 32'h2;
    ld_waddr  = 5'd11;
    ld_wdata  = 32'hA000_0011;
    #2;
    n_checks++;
    if (ld_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL full_ready_ld1: got %b expected 1", ld_ready);
    end
    step();
    fpu_wdata = 32'h3;
    ld_waddr  = 5'd12;
    ld_wdata  = 32'hA000_0012;
    #2;
    n_checks++;
    if (ld_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL full_ready_ld2: got %b expected 0", ld_ready);
    end
    step();
    fpu_we = 1'b0;
    #2;
    n_checks++;
    if (ld_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL full_no_fallthrough: got %b expected 0", ld_ready);
    end
    n_checks++;
    if (rdata[0] !== 32'h0) begin
      n_errors++;
      $display("FAIL full_f10_early: got %h expected %h", rdata[0], 32'h0);
    end
    step();
    #2;
    n_checks++;
    if (ld_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL full_ready_after_pop: got %b expected 1", ld_ready);
    end
    n_checks++;
    if (rdata[0] !== 32'hA000_0010) begin
      n_errors++;
      $display("FAIL drain_f10: got %h expected %h", rdata[0], 32'hA000_0010);
    end
    n_checks++;
    if (rdata[1] !== 32'h0) begin
      n_errors++;
      $display("FAIL drain_f11_early: got %h expected %h", rdata[1], 32'h0);
    end
    step();
    ld_valid = 1'b0;
    #2;
    n_checks++;
    if (rdata[1] !== 32'hA000_0011) begin
      n_errors++;
      $display("FAIL drain_f11: got %h expected %h", rdata[1], 32'hA000_0011);
    end
    n_checks++;
    if (rdata[2] !== 32'h0) begin
      n_errors++;
      $display("FAIL drain_f12_early: got %h expected %h", rdata[2], 32'h0);
    end
    step();
    #2;
    n_checks++;
    if (rdata[2] !== 32'hA000_0012) begin
      n_errors++;
      $display("FAIL drain_f12: got %h expected %h", rdata[2], 32'hA000_0012);
    end
    n_checks++;
    if (ld_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL drain_ready_end: got %b expected 1", ld_ready);
    end
  endtask

  task automatic test_issue_collision();
    raddr[0] = 5'd4;
    step();
    issue_valid = 1'b1;
    issue_addr  = 5'd4;
    step();
    fpu_we    = 1'b1;
    fpu_waddr = 5'd4;
    fpu_wdata = 32'h0000_0044;
    #2;
    n_checks++;
    if (issue_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL collide_ready_same_cycle: got %b expected 0", issue_ready);
    end
    step();
    issue_valid = 1'b0;
    fpu_we      = 1'b0;
    #2;
    n_checks++;
    if (rbusy[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL collide_pending_kept: got %b expected 1", rbusy[0]);
    end
    n_checks++;
    if (issue_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL collide_ready_after: got %b expected 0", issue_ready);
    end
    n_checks++;
    if (rdata[0] !== 32'h0000_0044) begin
      n_errors++;
      $display("FAIL collide_rdata: got %h expected %h", rdata[0], 32'h0000_0044);
    end
    step();
    fpu_we    = 1'b1;
    fpu_wdata = 32'h0000_0045;
    step();
    fpu_we = 1'b0;
    #2;
    n_checks++;
    if ({rbusy[0], issue_ready} !== 2'b01) begin
      n_errors++;
      $display("FAIL collide_cleanup: got %b expected 01", {rbusy[0], issue_ready});
    end
  endtask

  task automatic test_err();
    idle();
    raddr[0] = 5'd7;
    step();
    step();
    #2;
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++;
      $display("FAIL err_quiet: got %b expected 0", err);
    end
    step();
    fpu_we    = 1'b1;
    fpu_waddr = 5'd7;
    fpu_wdata = 32'h0000_0077;
    #2;
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++;
      $display("FAIL err_not_early: got %b expected 0", err);
    end
    step();
    fpu_we = 1'b0;
    #2;
    n_checks++;
    if (err !== ErrExp) begin
      n_errors++;
      $display("FAIL err_pulse: got %b expected %b", err, ErrExp);
    end
    step();
    #2;
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++;
      $display("FAIL err_one_cycle: got %b expected 0", err);
    end
  endtask

  task automatic test_reset_flush();
    raddr[0] = 5'd5;
    raddr[1] = 5'd22;
    raddr[2] = 5'd23;
    step();
    issue_valid = 1'b1;
    issue_addr  = 5'd5;
    fpu_we      = 1'b1;
    fpu_waddr   = 5'd21;
    fpu_wdata   = 32'h0000_0021;
    ld_valid    = 1'b1;
    ld_waddr    = 5'd22;
    ld_wdata    = 32'hB000_0022;
    step();
    issue_valid = 1'b0;
    ld_waddr    = 5'd23;
    ld_wdata    = 32'hB000_0023;
    step();
    ld_valid = 1'b0;
    #2;
    n_checks++;
    if ({ld_ready, rbusy[0]} !== 2'b01) begin
      n_errors++;
      $display("FAIL flush_setup: got %b expected 01", {ld_ready, rbusy[0]});
    end
    #1;
    rst_i  = 1'b1;
    fpu_we = 1'b0;
    #1;
    n_checks++;
    if (ld_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_ld_ready: got %b expected 1", ld_ready);
    end
    n_checks++;
    if (rbusy !== 3'b000) begin
      n_errors++;
      $display("FAIL flush_rbusy: got %b expected 000", rbusy);
    end
    step();
    step();
    rst_i = 1'b0;
    step();
    step();
    raddr[0] = 5'd3;
    #2;
    n_checks++;
    if (rdata[1] !== 32'h0 || rdata[2] !== 32'h0) begin
      n_errors++;
      $display("FAIL flush_loads_dropped: got %h %h expected 0 0", rdata[1], rdata[2]);
    end
    n_checks++;
    if (rdata[0] !== 32'h3F80_0000) begin
      n_errors++;
      $display("FAIL flush_mem_kept: got %h expected %h", rdata[0], 32'h3F80_0000);
    end
    n_checks++;
    if (rbusy !== 3'b000) begin
      n_errors++;
      $display("FAIL flush_rbusy_after: got %b expected 000", rbusy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_issue_fpu();
    test_fpu_and_load();
    test_buffer_full();
    test_issue_collision();
    test_err();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ibex_fp_regfile_mp.md
# ibex_fp_regfile_mp

Multi-port floating-point register file for FPGA targets, with a per-register pending scoreboard and a deferred-write buffer. It serves the FPU issue stage with up to three asynchronous read ports for fused multiply-add operands. It merges two writeback sources, the FPU result and the FP load, onto the single physical write port of an inferred LUTRAM. It sits between the ID/issue stage and the FPU/LSU writeback paths.

## Interface
- DataWidth, 32: register width in bits.
- NumRegs, 32: number of registers. Must be a power of two. AW = log2(NumRegs).
- NumRead, 3: read ports, 1..4.
- WbDepth, 2: entries in the load-writeback buffer, ≥1.
- ZeroReg, 0: 1 forces register 0 to read WordZeroVal and ignores writes to it.
- WordZeroVal, '0: initial contents of every register.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset. Asynchronous assertion, active-high.
- raddr_i  in  NumRead×AW  read addresses.
- rdata_o  out  NumRead×DataWidth  read data, combinational.
- rbusy_o  out  NumRead  pending bit of the addressed register.
- issue_valid_i  in  1  marks issue_addr_i pending on this edge.
- issue_addr_i  in  AW  destination register of the issued instruction.
- issue_ready_o  out  1  high when the pending bit of issue_addr_i is clear.
- fpu_we_i  in  1  FPU writeback valid. Always accepted.
- fpu_waddr_i  in  AW  FPU writeback address.
- fpu_wdata_i  in  DataWidth  FPU writeback data.
- ld_valid_i  in  1  load writeback valid.
- ld_ready_o  out  1  high when the load buffer is not full.
- ld_waddr_i  in  AW  load writeback address.
- ld_wdata_i  in  DataWidth  load writeback data.
- err_o  out  1  registered one-cycle error pulse.

## Operation
- Storage:
  - LUTRAM with one write port and no reset.
  - Initialised to WordZeroVal.
- Reads:
  - rdata_o[i] = mem[raddr_i[i]].
  - Returns WordZeroVal when ZeroReg=1 and the address is 0.
  - No forwarding. Consumers must stall while rbusy_o[i]=1.
- Scoreboard:
  - pending[NumRegs] is set by issue_valid_i and cleared when a write commits to memory.
  - When issue and commit target the same register in the same cycle, the set wins.
  - issue_ready_o ignores a same-cycle clear; it stays low (conservative).
  - Issuing with issue_ready_o=0 is illegal and flagged by err_o.
- Write arbitration, once per cycle, in priority order:
  1. fpu_we_i commits directly.
  2. Else if the buffer is non-empty, the buffer head commits.
  3. Else if a load handshake (ld_valid_i && ld_ready_o) occurs, the load commits directly and bypasses the buffer.
  - Any load handshake that does not commit directly is enqueued at the buffer tail.
  - Loads commit in arrival order.
- ld_ready_o:
  - Equals !full.
  - Does not depend on ld_valid_i.
  - While full, a same-cycle drain does not raise it (no fall-through).
- Writes to register 0 with ZeroReg=1 are dropped but still clear pending[0].

## Timing
- Read latency: 0 cycles (combinational).
- Direct commit: data is visible on rdata_o and pending clears after the next edge.
- Buffered load: commits on the first cycle with fpu_we_i=0 at or after the cycle following enqueue.
- Worst-case buffer latency is unbounded while the FPU writes every cycle; the FPU write rate is the system's responsibility.
- Reset values:
  - pending all 0.
  - Buffer empty, so ld_ready_o=1.
  - issue_ready_o=1.
  - rbusy_o=0.
  - err_o=0.
  - Memory contents unchanged.
- Reset mid-operation: buffered loads are discarded and all pending bits clear. This is the intended flush.

## Configuration
- IBEX_FP_RF_WB_CHECK_EN defined:
  - err_o pulses one cycle after any of the following:
    - a commit to a register whose pending bit is clear;
    - an issue when issue_ready_o=0;
    - a load handshake while full.
- IBEX_FP_RF_WB_CHECK_EN undefined:
  - err_o tied to 0 and the check logic is removed.
  - All other behaviour is identical.

## Structure
- Package ibex_fp_rf_pkg holds:
  - typedef fp_wb_entry_t {addr, data}, parametrised by width via the package parameter;
  - localparams for default widths.
- Sub-module ibex_fp_rf_wb_fifo:
  - circular buffer of fp_wb_entry_t;
  - WbDepth entries with head/tail pointers and a count;
  - pointers wrap at WbDepth (non-power-of-two depths supported);
  - outputs full/empty/head; inputs push/pop.
- Top level holds memory, scoreboard, arbitration mux and error check.

## Test plan
- Reset, then read all ports at addresses 0, 5, 31 -> rdata=WordZeroVal, rbusy=0, ld_ready_o=1.
- Issue f3, FPU writes f3=0x3F800000 two cycles later -> rbusy high in between; after the write edge rdata=0x3F800000 and rbusy=0.
- FPU writes f1 and load writes f2=0xDEADBEEF in the same cycle -> f1 commits and f2 is buffered. The next idle cycle commits f2, pending[2] clears one cycle later than pending[1].
- WbDepth=2, FPU writing every cycle, three loads -> ld_ready_o drops after the second load. When the FPU idles, the loads drain in order and ld_ready_o rises the cycle after the first pop.
- Issue f4 in the same cycle a commit to f4 lands -> pending[4] stays 1, issue_ready_o low.
- With the macro, an FPU write to non-pending f7 -> err_o=1 for exactly one cycle. Without the macro, err_o stays 0.
- rst_i pulsed with 2 buffered loads -> buffer empty, loads never reach memory, all rbusy=0.
